// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, majority-vote bit sampling,
// optional even/odd parity and registered one-cycle result pulses.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e state_q, state_d;

    logic sync_q, rx_s_q;

    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [2:0]            samp_q, samp_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_flag_q, par_flag_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic tick_last;
    logic bit_last;
    logic bit_val;

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= RX_IN;
            rx_s_q <= sync_q;
        end
    end

    assign tick_last = (tick_q == TICK_LAST);
    assign bit_last  = (bit_cnt_q == BIT_LAST);
    assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                       (samp_q[1] & samp_q[2]);

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick_last) begin
                    state_d = bit_val ? StIdle : StData;
                end
            end
            StData: begin
                if (tick_last && bit_last) begin
                    state_d = par_en_q ? StParity : StStop;
                end
            end
            StParity: begin
                if (tick_last) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (tick_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and output next-state logic
    always_comb begin
        tick_d     = tick_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        samp_d     = samp_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_flag_d = par_flag_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (state_q == StIdle) begin
            // The IDLE cycle that sees the low line is tick 0 of the start bit.
            tick_d = rx_s_q ? '0 : TICK_W'(1);
            if (!rx_s_q) begin
                par_en_d   = PAR_EN;
                par_typ_d  = PAR_TYP;
                par_flag_d = 1'b0;
                bit_cnt_d  = '0;
            end
        end else begin
            tick_d = tick_last ? '0 : tick_q + 1'b1;
            if (tick_q == TICK_S0) samp_d[0] = rx_s_q;
            if (tick_q == TICK_S1) samp_d[1] = rx_s_q;
            if (tick_q == TICK_S2) samp_d[2] = rx_s_q;
        end

        if (tick_last) begin
            unique case (state_q)
                StData: begin
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
                end
                StParity: begin
                    if (bit_val != ((^shift_q) ^ par_typ_q)) begin
                        par_flag_d = 1'b1;
                    end
                end
                StStop: begin
                    if (!par_flag_q && bit_val) begin
                        dv_d     = 1'b1;
                        p_data_d = shift_q;
                    end else begin
                        pe_d = par_flag_q;
                        se_d = ~bit_val;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tick_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            samp_q     <= samp_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_flag_q <= par_flag_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames push expected results, a monitor pops
// and compares them whenever the receiver pulses an output.
module tb_uart_rx;

    localparam int OS = 8;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] model_data;
    int         cyc;
    int         n_checks;
    int         n_errors;
    int         last_dv_cyc;
    int         dv_gap;

    uart_rx #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(OS)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding frame.
    always @(negedge CLK) begin
        exp_t e;
        if (RST && (data_valid || par_err || stp_err)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {29'b0, data_valid, par_err, stp_err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("data_valid", {31'b0, data_valid}, {31'b0, e.dv});
                check("par_err", {31'b0, par_err}, {31'b0, e.pe});
                check("stp_err", {31'b0, stp_err}, {31'b0, e.se});
                check("p_data", {24'b0, P_DATA}, {24'b0, e.data});
                check("latency", cyc, e.due);
                if (data_valid) begin
                    dv_gap      = cyc - last_dv_cyc;
                    last_dv_cyc = cyc;
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        RX_IN = b;
        repeat (OS) @(negedge CLK);
    endtask

    // Must be called at a negedge; the fall is in the current cycle.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic flip_par, input logic stop_val);
        exp_t e;
        int   nbits;
        logic pbit;
        nbits = pen ? 11 : 10;
        pbit  = (^d) ^ ptyp ^ flip_par;
        e.pe  = pen & flip_par;
        e.se  = ~stop_val;
        e.dv  = ~e.pe & ~e.se;
        if (e.dv) model_data = d;
        e.data = model_data;
        e.due  = cyc + nbits * OS + 2;
        sb_q.push_back(e);
        PAR_EN  = pen;
        PAR_TYP = ptyp;
        send_bit(1'b0);
        // Mid-frame changes must be ignored.
        PAR_EN  = ~pen;
        PAR_TYP = ~ptyp;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(stop_val);
        RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall;
        n_checks    = 0;
        n_errors    = 0;
        cyc         = 0;
        model_data  = 8'h00;
        last_dv_cyc = 0;
        dv_gap      = 0;
        RST         = 1'b0;
        RX_IN       = 1'b1;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_p_data", {24'b0, P_DATA}, 32'd0);
        check("rst_dv", {31'b0, data_valid}, 32'd0);
        check("rst_pe", {31'b0, par_err}, 32'd0);
        check("rst_se", {31'b0, stp_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        RST = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(20);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(20);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        check("idle_after_stp_err", {31'b0, busy}, 32'd0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(20);

        // Short glitch: start bit rejected, no pulse.
        fall  = cyc;
        RX_IN = 1'b0;
        repeat (3) @(negedge CLK);
        RX_IN = 1'b1;
        while (cyc < fall + 9) @(negedge CLK);
        check("glitch_busy_hi", {31'b0, busy}, 32'd1);
        @(negedge CLK);
        check("glitch_busy_lo", {31'b0, busy}, 32'd0);
        idle(20);

        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(20);
        check("b2b_gap", dv_gap, 32'd80);

        send_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(20);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(20);
        for (int k = 0; k < 4; k++) begin
            send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
            idle(4);
        end
        idle(20);

        // Reset in the middle of the data bits abandons the frame.
        RX_IN = 1'b0;
        repeat (3 * OS) @(negedge CLK);
        RST = 1'b0;
        #1;
        check("midrst_dv", {31'b0, data_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_p_data", {24'b0, P_DATA}, 32'd0);
        model_data = 8'h00;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        idle(10);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(20);

        for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge CLK);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
